// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial bit in, aligned 10-bit words and status out.
interface serial_paralelo_if;
    logic       entrada;
    logic [9:0] salidas;
    logic       valido;
    logic       es_coma;
    logic       alineado;

    modport master (output entrada, input salidas, valido, es_coma, alineado);
    modport slave  (input entrada, output salidas, valido, es_coma, alineado);
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: LSB-first 10-bit deserializer that aligns on K28.5 commas of either disparity
module serial_paralelo #(
    parameter logic [9:0] COMA            = 10'h17C,
    parameter int         UMBRAL_REALINEO = 3
) (
    input logic              clk,
    input logic              reset_L,
    serial_paralelo_if.slave bus
);
    typedef enum logic {BUSCANDO, ALINEADO} estado_t;
    localparam logic [2:0] UMBRAL = 3'(UMBRAL_REALINEO);

    estado_t    estado_q, estado_d;
    logic [9:0] ventana_q, salidas_q, salidas_d, sig;
    logic [3:0] fase_q, fase_d;
    logic [2:0] cnt_fuera_q, cnt_fuera_d;
    logic       valido_q, valido_d, es_coma_q, es_coma_d;
    logic       coma_det, frontera, captura, alin;

    assign sig      = {bus.entrada, ventana_q[9:1]};
    assign coma_det = (sig == COMA) || (sig == ~COMA);
    assign alin     = estado_q == ALINEADO;
    assign frontera = alin && fase_q == 4'd9;
    // acquisition and threshold realignment take identical actions
    assign captura  = coma_det && !frontera && (!alin || cnt_fuera_q + 3'd1 == UMBRAL);

    always_comb begin
        estado_d    = captura ? ALINEADO : estado_q;
        salidas_d   = (captura || frontera) ? sig : salidas_q;
        valido_d    = captura || frontera;
        es_coma_d   = captura ? 1'b1 : frontera ? coma_det : es_coma_q;
        fase_d      = (captura || frontera) ? 4'd0 : alin ? fase_q + 4'd1 : fase_q;
        cnt_fuera_d = (captura || (frontera && coma_det)) ? 3'd0 :
                      (alin && coma_det) ? cnt_fuera_q + 3'd1 : cnt_fuera_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado_q    <= BUSCANDO;
            ventana_q   <= '0;
            salidas_q   <= '0;
            valido_q    <= 1'b0;
            es_coma_q   <= 1'b0;
            fase_q      <= '0;
            cnt_fuera_q <= '0;
        end else begin
            estado_q    <= estado_d;
            ventana_q   <= sig;
            salidas_q   <= salidas_d;
            valido_q    <= valido_d;
            es_coma_q   <= es_coma_d;
            fase_q      <= fase_d;
            cnt_fuera_q <= cnt_fuera_d;
        end
    end

    assign bus.salidas  = salidas_q;
    assign bus.valido   = valido_q;
    assign bus.es_coma  = es_coma_q;
    assign bus.alineado = alin;
endmodule
